br_update_queue: RTL
====================

Name: br_update_queue

Overview:
- Decoupling FIFO between the integer-pipe branch-resolution outputs and the branch predictor's PHT/history update write ports.
- Accepts up to IN_WIDTH resolved branch results per cycle and drains them in order, up to OUT_WIDTH per cycle, to the predictor.
- Never presents two same-cycle writes to the same PHT index, so predictor bank conflicts and write-drop logic are not needed.
- Holds drain while the predictor runs its table-initialisation sequence.

Parameters:
- IN_WIDTH, 2, branch results accepted per cycle (matches INT_ISSUE_WIDTH).
- OUT_WIDTH, 2, entries drained per cycle (matches predictor write ports).
- DEPTH, 8, queue entries; power of two, >= 2*IN_WIDTH.
- ADDR_WIDTH, 32, branch PC width.
- INDEX_BITS, 10, PHT index width (PHT_PAP_BITS).
- INDEX_LSB, 2, lowest PC bit of the index (INSN_ADDR_BIT_WIDTH + GAS_OFFSET).
- HIST_BITS, 10, per-branch local history width.
- CTR_WIDTH, 2, saturating counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  IN_WIDTH  per-slot branch result valid.
- in_addr  in  IN_WIDTH*ADDR_WIDTH  branch PC per slot.
- in_taken  in  IN_WIDTH  resolved direction.
- in_mispred  in  IN_WIDTH  prediction was wrong.
- in_cond  in  IN_WIDTH  conditional branch.
- in_hist  in  IN_WIDTH*HIST_BITS  history used at predict time.
- in_ctr  in  IN_WIDTH*CTR_WIDTH  counter value used at predict time.
- in_ready  out  1  queue can take a full IN_WIDTH group this cycle.
- drain_en  in  1  predictor can accept writes (low during predictor init).
- out_valid  out  OUT_WIDTH  drain slot valid.
- out_index  out  OUT_WIDTH*INDEX_BITS  PHT index = addr[INDEX_LSB+INDEX_BITS-1:INDEX_LSB].
- out_hist, out_taken, out_mispred, out_cond  out  per-slot passthrough of the stored fields.
- out_ctr_next  out  OUT_WIDTH*CTR_WIDTH  saturated counter: taken ? min(ctr+1, max) : max(ctr-1, 0).
- count  out  log2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: a valid result was dropped.

Behaviour:
- Reset (synchronous, rst high at a clock edge): head=tail=count=0, overflow=0. Outputs in the following cycle: out_valid=0, in_ready=1. Reset mid-operation discards all queued entries.
- in_ready = (DEPTH - count >= IN_WIDTH). It is combinational from registered count and does not depend on in_valid.
- Enqueue when in_ready: valid slots are compacted in slot order (slot 0 first) and written at tail. tail and count advance by popcount(in_valid). Invalid slots consume no entry.
- If in_valid is nonzero while in_ready=0: nothing is enqueued, overflow is set to 1 and stays 1 until reset.
- Drain presentation is combinational from head entries and gated by drain_en.
  - out_valid[0] = drain_en && count>=1.
  - out_valid[1] = drain_en && count>=2 && index(head+1) != index(head).
  - On a same-index collision, entry head+1 is held and presented as slot 0 in the next cycle (serialised).
- Pop: when drain_en=1, every presented out_valid slot is consumed at the clock edge; head advances by the number of valid outputs. There is no backpressure beyond drain_en.
- Latency: an entry enqueued at edge N is visible on out_* after edge N, if it is at the head; minimum one cycle, no bypass.
- Same-cycle enqueue and dequeue: count_next = count + pushed - popped. A pop frees space only for the next cycle's in_ready.
- head, tail and the read index head+1 all wrap modulo DEPTH.
- Ordering: strict FIFO. A later entry never drains before an earlier one.
- The counter update uses saturating arithmetic in CTR_WIDTH bits: never wraps from max to 0 or from 0 to max.

Test Plan:
- Reset, then in_valid=2'b11 with distinct addrs 0x100/0x204, drain_en=1 -> next cycle out_valid=2'b11 with in-order indexes 0x40/0x81, count returns to 0 one cycle later.
- Two enqueues with addr 0x100 both, drain_en=1 -> cycle1 out_valid=2'b01; cycle2 out_valid=2'b01 for the second entry; never 2'b11.
- drain_en=0, enqueue 2/cycle for 4 cycles (DEPTH=8) -> count=8, in_ready=0. A 5th push sets overflow=1 and leaves count=8. Then drain_en=1 drains all 8 in order over 4 cycles.
- in_ctr=3 with taken=1 -> out_ctr_next=3; in_ctr=0 with taken=0 -> 0; in_ctr=1 with taken=1 -> 2.
- Wrap: push/pop 1 per cycle for 20 cycles -> data order preserved across pointer wrap, count stays 1.
- Assert rst with count=5 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0, in_ready=1.

Source files
------------

// File: rtl/br_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : br_update_queue
// Description : In-order queue from branch resolution to the predictor update
//               ports. Drained slots never share a PHT index in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module br_update_queue #(
    parameter int IN_WIDTH   = 2,
    parameter int OUT_WIDTH  = 2,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 10,
    parameter int INDEX_LSB  = 2,
    parameter int HIST_BITS  = 10,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_WIDTH-1:0]             in_valid,
    input  logic [IN_WIDTH*ADDR_WIDTH-1:0]  in_addr,
    input  logic [IN_WIDTH-1:0]             in_taken,
    input  logic [IN_WIDTH-1:0]             in_mispred,
    input  logic [IN_WIDTH-1:0]             in_cond,
    input  logic [IN_WIDTH*HIST_BITS-1:0]   in_hist,
    input  logic [IN_WIDTH*CTR_WIDTH-1:0]   in_ctr,
    output logic                            in_ready,
    input  logic                            drain_en,
    output logic [OUT_WIDTH-1:0]            out_valid,
    output logic [OUT_WIDTH*INDEX_BITS-1:0] out_index,
    output logic [OUT_WIDTH*HIST_BITS-1:0]  out_hist,
    output logic [OUT_WIDTH-1:0]            out_taken,
    output logic [OUT_WIDTH-1:0]            out_mispred,
    output logic [OUT_WIDTH-1:0]            out_cond,
    output logic [OUT_WIDTH*CTR_WIDTH-1:0]  out_ctr_next,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     C_IN_LIMIT = CNT_W'(DEPTH - IN_WIDTH);
    localparam logic [CTR_WIDTH-1:0] C_CTR_MAX  = '1;

    // Only the index field of the PC is kept; the rest is deliberately dropped.
    logic [INDEX_BITS-1:0] idx_q  [DEPTH];
    logic [HIST_BITS-1:0]  hist_q [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_q  [DEPTH];
    logic [DEPTH-1:0]      taken_q, mispred_q, cond_q;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [PTR_W-1:0] w_wr_ptr [IN_WIDTH];
    logic [PTR_W-1:0] w_rd_ptr [OUT_WIDTH];
    logic [CNT_W-1:0] w_push_cnt, w_pop_cnt;
    logic             w_push_en, w_blocked, w_collide;
    logic             w_unused_addr;

    assign w_unused_addr = ^in_addr;
    assign in_ready      = (count_q <= C_IN_LIMIT);
    assign w_push_en     = in_ready;
    assign count         = count_q;
    assign overflow      = overflow_q;

    // Compact valid slots onto consecutive entries starting at tail.
    always_comb begin
        w_push_cnt = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_wr_ptr[i] = tail_q + w_push_cnt[PTR_W-1:0];
            w_push_cnt  = w_push_cnt + CNT_W'(in_valid[i]);
        end
    end

    // A slot drains only if every earlier slot drains and no earlier slot
    // targets the same PHT index; the first blocked slot stops the scan.
    always_comb begin
        w_pop_cnt = '0;
        w_blocked = 1'b0;
        w_collide = 1'b0;
        out_valid = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            w_rd_ptr[k] = head_q + PTR_W'(k);
            w_collide   = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (idx_q[w_rd_ptr[j]] == idx_q[w_rd_ptr[k]]) begin
                    w_collide = 1'b1;
                end
            end
            if (drain_en && !w_blocked && !w_collide && (count_q > CNT_W'(k))) begin
                out_valid[k] = 1'b1;
                w_pop_cnt    = w_pop_cnt + CNT_W'(1);
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    always_comb begin
        head_d     = head_q + w_pop_cnt[PTR_W-1:0];
        tail_d     = tail_q;
        count_d    = count_q - w_pop_cnt;
        overflow_d = overflow_q | ((|in_valid) & ~in_ready);
        if (w_push_en) begin
            tail_d  = tail_q + w_push_cnt[PTR_W-1:0];
            count_d = count_q + w_push_cnt - w_pop_cnt;
        end
    end

    generate
        for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_out
            logic [CTR_WIDTH-1:0] w_ctr;
            assign w_ctr = ctr_q[w_rd_ptr[k]];
            assign out_index[k*INDEX_BITS +: INDEX_BITS] = idx_q[w_rd_ptr[k]];
            assign out_hist[k*HIST_BITS +: HIST_BITS]    = hist_q[w_rd_ptr[k]];
            assign out_taken[k]   = taken_q[w_rd_ptr[k]];
            assign out_mispred[k] = mispred_q[w_rd_ptr[k]];
            assign out_cond[k]    = cond_q[w_rd_ptr[k]];
            assign out_ctr_next[k*CTR_WIDTH +: CTR_WIDTH] =
                taken_q[w_rd_ptr[k]] ? ((w_ctr == C_CTR_MAX) ? w_ctr : w_ctr + CTR_WIDTH'(1))
                                     : ((w_ctr == '0)        ? w_ctr : w_ctr - CTR_WIDTH'(1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_en) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (in_valid[i]) begin
                    idx_q[w_wr_ptr[i]]     <= in_addr[i*ADDR_WIDTH + INDEX_LSB +: INDEX_BITS];
                    hist_q[w_wr_ptr[i]]    <= in_hist[i*HIST_BITS +: HIST_BITS];
                    ctr_q[w_wr_ptr[i]]     <= in_ctr[i*CTR_WIDTH +: CTR_WIDTH];
                    taken_q[w_wr_ptr[i]]   <= in_taken[i];
                    mispred_q[w_wr_ptr[i]] <= in_mispred[i];
                    cond_q[w_wr_ptr[i]]    <= in_cond[i];
                end
            end
        end
    end
endmodule
`default_nettype wire
